// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Up/down modulo counter with a wrap or saturate mode, a synchronous load
//   that rejects out-of-range values, and bound-crossing flags.
//
//   Parameters
//     WIDTH    : counter width in bits (2..16)
//     MODULUS  : count range is 0..MODULUS-1 (2..2**WIDTH)
//
//   Ports
//     clk      : in  - rising-edge clock
//     reset    : in  - asynchronous active-low reset
//     en       : in  - count enable
//     up       : in  - direction, 1 = up, 0 = down
//     sat      : in  - 0 = wrap at the bounds, 1 = saturate at the bounds
//     load     : in  - synchronous load strobe, takes priority over en
//     load_val : in  - value to load, ignored (load_err) if >= MODULUS
//     clr_ovf  : in  - clears the sticky overflow flag
//     Q        : out - registered count
//     tc       : out - terminal count for the current direction (combinational)
//     wrap     : out - one-cycle pulse after an edge that crossed a bound
//     ovf      : out - sticky copy of wrap
//     load_err : out - one-cycle pulse after an edge that rejected a load
module updown_mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    // Range check done at 32 bits so a full-range modulus needs no special case.
    logic [31:0] load_val_ext;
    logic        load_legal;

    assign load_val_ext = 32'(load_val);
    assign load_legal   = (load_val_ext < 32'(MODULUS));

    always_comb begin
        q_d        = q_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        ovf_d      = ovf_q;

        if (load) begin
            if (load_legal) begin
                q_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_q == MAX_VAL) begin
                    if (!sat) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    if (!sat) begin
                        q_d    = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end

        // A fresh wrap on the same edge as a clear keeps the flag set.
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wrap_d) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q        <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign Q        = q_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;
    assign tc       = up ? (q_q == MAX_VAL) : (q_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances (MODULUS 8 and 6, both WIDTH 3)
// share one stimulus stream and are compared against a reference model.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en, up, sat, load, clr_ovf;
    logic [2:0] load_val;

    logic [2:0] q8, q6;
    logic       tc8, tc6, wrap8, wrap6, ovf8, ovf6, lerr8, lerr6;

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 -> MODULUS 8, index 1 -> MODULUS 6
    int mod_m[2] = '{8, 6};
    int mq[2];
    int mw[2];
    int mo[2];
    int me[2];

    updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .Q(q8), .tc(tc8), .wrap(wrap8),
        .ovf(ovf8), .load_err(lerr8)
    );

    updown_mod_counter #(.WIDTH(3), .MODULUS(6)) u_m6 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .Q(q6), .tc(tc6), .wrap(wrap6),
        .ovf(ovf6), .load_err(lerr6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // model: one edge for counter i, from the rules of the count range
    task automatic model_edge(input int i);
        int m, nxt;
        m = mod_m[i];
        mw[i] = 0;
        me[i] = 0;
        if (load) begin
            if (int'(load_val) < m) mq[i] = int'(load_val);
            else me[i] = 1;
        end else if (en) begin
            nxt = up ? mq[i] + 1 : mq[i] - 1;
            if (nxt < 0 || nxt >= m) begin
                if (!sat) begin
                    mq[i] = (nxt + m) % m;
                    mw[i] = 1;
                end
            end else begin
                mq[i] = nxt;
            end
        end
        mo[i] = (mo[i] != 0 && !clr_ovf) || (mw[i] != 0) ? 1 : 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mw[i] = 0; mo[i] = 0; me[i] = 0;
        end
    endtask

    function automatic int exp_tc(input int i);
        return up ? int'(mq[i] == mod_m[i] - 1) : int'(mq[i] == 0);
    endfunction

    task automatic check_all();
        check("m8_q",    int'(q8),    mq[0]);
        check("m8_tc",   int'(tc8),   exp_tc(0));
        check("m8_wrap", int'(wrap8), mw[0]);
        check("m8_ovf",  int'(ovf8),  mo[0]);
        check("m8_lerr", int'(lerr8), me[0]);
        check("m6_q",    int'(q6),    mq[1]);
        check("m6_tc",   int'(tc6),   exp_tc(1));
        check("m6_wrap", int'(wrap6), mw[1]);
        check("m6_ovf",  int'(ovf6),  mo[1]);
        check("m6_lerr", int'(lerr6), me[1]);
    endtask

    // driver: inputs are set just after a falling edge; one call = one rising edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic e, input logic u, input logic s,
                          input logic l, input logic [2:0] lv, input logic c);
        en = e; up = u; sat = s; load = l; load_val = lv; clr_ovf = c;
    endtask

    // asynchronous reset asserted between edges, held across one rising edge
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b1;
        #1;
    endtask

    int seq33[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int seq34[7]  = '{5, 4, 3, 2, 1, 0, 5};
    int seq35[6]  = '{4, 3, 2, 1, 0, 0};

    initial begin
        reset = 1'b0;
        set_in(0, 1, 0, 0, 3'd0, 0);
        model_reset();
        #12;
        check_all();
        check("rst_tc_down", int'(tc8), 0); // up=1 here, Q=0 is not terminal
        @(negedge clk);
        reset = 1'b1;
        #1;

        // count up through the bound with wrap mode
        set_in(1, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("up8_q", int'(q8), seq33[i]);
            check("up8_wrap", int'(wrap8), (i == 7) ? 1 : 0);
        end
        check("up8_ovf", int'(ovf8), 1);

        // count down from 0 with wrap mode
        pulse_reset();
        set_in(1, 0, 0, 0, 3'd0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("dn6_q", int'(q6), seq34[i]);
            check("dn6_wrap", int'(wrap6), (i == 0 || i == 6) ? 1 : 0);
        end

        // saturate at both bounds
        set_in(0, 1, 1, 1, 3'd5, 0);
        tick();
        check("sat6_load", int'(q6), 5);
        set_in(1, 1, 1, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat6_hi_q", int'(q6), 5);
            check("sat6_hi_tc", int'(tc6), 1);
            check("sat6_hi_wrap", int'(wrap6), 0);
        end
        up = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat6_lo_q", int'(q6), seq35[i]);
            check("sat6_lo_tc", int'(tc6), (seq35[i] == 0) ? 1 : 0);
        end

        // illegal then legal load
        set_in(0, 1, 0, 1, 3'd7, 0);
        tick();
        check("ld6_bad_q", int'(q6), 0);
        check("ld6_bad_err", int'(lerr6), 1);
        check("ld8_7_err", int'(lerr8), 0);
        set_in(0, 1, 0, 1, 3'd7, 0);
        tick();
        check("ld6_bad_err2", int'(lerr6), 1);
        set_in(0, 1, 0, 1, 3'd3, 0);
        tick();
        check("ld6_ok_q", int'(q6), 3);
        check("ld6_ok_err", int'(lerr6), 0);

        // load wins over en; clear collides with a new wrap
        set_in(1, 1, 0, 1, 3'd2, 0);
        tick();
        check("ld_pri_q6", int'(q6), 2);
        check("ld_pri_q8", int'(q8), 2);
        set_in(0, 0, 0, 1, 3'd0, 0);
        tick();
        set_in(1, 0, 0, 0, 3'd0, 1);
        tick();
        check("clr_vs_wrap_q6", int'(q6), 5);
        check("clr_vs_wrap_ovf6", int'(ovf6), 1);
        set_in(0, 0, 0, 0, 3'd0, 1);
        tick();
        check("clr_ovf6", int'(ovf6), 0);

        // reset mid-count overrides load/en, then counting restarts from 0
        set_in(0, 1, 0, 1, 3'd4, 0);
        tick();
        check("pre_rst_q6", int'(q6), 4);
        set_in(1, 0, 0, 1, 3'd3, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_q6", int'(q6), 0);
        check("async_ovf6", int'(ovf6), 0);
        check("async_tc6", int'(tc6), 1);
        tick();
        check("rst_hold_q6", int'(q6), 0);
        reset = 1'b1;
        set_in(1, 1, 0, 0, 3'd0, 0);
        tick();
        check("post_rst_q6", int'(q6), 1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
